// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM sequencing the multicycle RV32I datapath
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       flag_zero,
  input  logic       flag_lt,
  input  logic       flag_ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] extend_ctrl,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_dbg
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMREAD = 4'd4,
    MEMWB = 4'd5, MEMWRITE = 4'd6, EXECR = 4'd7, EXECI = 4'd8, ALUWB = 4'd9,
    BRANCH = 4'd10, JAL = 4'd11, JALR = 4'd12, LUI = 4'd13, TRAP = 4'd15
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
    OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic timeout, cond, taken;
  assign state_dbg = state;
  // Watchdog fires on the waiting cycle whose increment would reach the limit
  assign timeout = (MEM_TIMEOUT != 0) && mem_req && !mem_ready && (cnt + CW'(1) == CW'(MEM_TIMEOUT));
  assign cond = funct3[2] ? (funct3[1] ? flag_ltu : flag_lt) : flag_zero;
  assign taken = (funct3[2] || !funct3[1]) && (cond ^ funct3[0]);
  assign extend_ctrl = (op == OP_SW) ? 3'b001 :
                       (op == OP_B) ? 3'b010 :
                       (op == OP_LUI || op == OP_AUIPC) ? 3'b011 :
                       (op == OP_JAL) ? 3'b100 : 3'b000;
  // Next-state selection; a watchdog timeout overrides everything
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = FETCH;
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE:   nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
                      (op == OP_R) ? EXECR :
                      (op == OP_I) ? EXECI :
                      (op == OP_B) ? BRANCH :
                      (op == OP_JAL) ? JAL :
                      (op == OP_JALR) ? JALR :
                      (op == OP_LUI) ? LUI :
                      (op == OP_AUIPC) ? ALUWB : TRAP;
      MEMADR:   nxt = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
      MEMWB, ALUWB, BRANCH, LUI: nxt = FETCH;
      EXECR, EXECI, JAL: nxt = ALUWB;
      JALR:     nxt = JAL;
      default:  nxt = TRAP;
    endcase
    if (timeout) nxt = TRAP;
  end
  // State, watchdog counter and sticky trap flags; counter restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= (nxt != state) ? '0 : (mem_req && !mem_ready) ? cnt + CW'(1) : cnt;
      illegal <= illegal | (state == DECODE && nxt == TRAP);
      bus_err <= bus_err | timeout;
    end
  end
  // Moore decode of datapath controls; FETCH strobes and branch pc_write follow their inputs
  always_comb begin
    mem_req = 1'b0;
    mem_write = 1'b0;
    adr_src = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    reg_write = 1'b0;
    result_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR, EXECI, JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op = (state == EXECI) ? 2'b10 : 2'b00;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write = 1'b1;
      end
      MEMWRITE: begin
        mem_req = 1'b1;
        mem_write = 1'b1;
        adr_src = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op = 2'b10;
      end
      ALUWB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op = 2'b01;
        pc_write = taken;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write = 1'b1;
      end
      LUI: begin
        result_src = 2'b11;
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multicycle control FSM
module tb_multicycle_controller;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] op = 7'b0010011;
  logic [2:0] funct3 = 3'b000;
  logic flag_zero = 1'b0, flag_lt = 1'b0, flag_ltu = 1'b0, mem_ready = 1'b1;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal, bus_err;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] extend_ctrl;
  logic [3:0] state_dbg;
  logic [4:0] strobes;
  int errors = 0, checks = 0;
  assign strobes = {mem_req, mem_write, ir_write, pc_write, reg_write};
  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .flag_zero(flag_zero),
    .flag_lt(flag_lt), .flag_ltu(flag_ltu), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .extend_ctrl(extend_ctrl), .illegal(illegal),
    .bus_err(bus_err), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_strobes", 32'(strobes), 0);
    chk("rst_flags", 32'({illegal, bus_err}), 0);
    chk("rst_muxes", 32'({result_src, alu_src_a, alu_src_b, alu_op}), 0);
    tick();
    chk("rst_hold", 32'(state_dbg), 0);
    rst_n = 1'b1;
    tick();
    #1;
    chk("addi_fetch", 32'(state_dbg), 1);
    chk("fetch_strobes", 32'(strobes), 32'b10110);
    chk("fetch_mux", 32'({adr_src, alu_src_a, alu_src_b, alu_op, result_src}), 32'b0_00_10_00_10);
    chk("addi_ext", 32'(extend_ctrl), 0);
    tick();
    chk("addi_decode", 32'(state_dbg), 2);
    chk("decode_mux", 32'({alu_src_a, alu_src_b, alu_op}), 32'b01_01_00);
    tick();
    chk("addi_execi", 32'(state_dbg), 8);
    chk("execi_mux", 32'({alu_src_a, alu_src_b, alu_op, reg_write}), 32'b10_01_10_0);
    tick();
    chk("addi_aluwb", 32'(state_dbg), 9);
    chk("aluwb_wr", 32'({reg_write, result_src}), 32'b1_00);
    tick();
    chk("addi_refetch", 32'(state_dbg), 1);
    op = 7'b0000011;
    #1;
    chk("lw_ext", 32'(extend_ctrl), 0);
    tick();
    tick();
    chk("lw_memadr", 32'(state_dbg), 3);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      chk("lw_memread", 32'({state_dbg, mem_req, adr_src, mem_write}), 32'b0100_1_1_0);
      tick();
    end
    chk("lw_memwb", 32'({state_dbg, result_src, reg_write}), 32'b0101_01_1);
    tick();
    chk("lw_done", 32'(state_dbg), 1);
    op = 7'b1100011;
    funct3 = 3'b000;
    flag_zero = 1'b1;
    #1;
    chk("br_ext_fetch", 32'(extend_ctrl), 3'b010);
    tick();
    tick();
    chk("br_state", 32'(state_dbg), 10);
    chk("br_mux", 32'({alu_src_a, alu_src_b, alu_op, result_src}), 32'b10_00_01_00);
    chk("beq_taken", 32'(pc_write), 1);
    chk("br_ext", 32'(extend_ctrl), 3'b010);
    funct3 = 3'b001;
    #1;
    chk("bne_not_taken", 32'(pc_write), 0);
    funct3 = 3'b110;
    flag_ltu = 1'b1;
    #1;
    chk("bltu_taken", 32'(pc_write), 1);
    funct3 = 3'b010;
    #1;
    chk("f3_010_never", 32'(pc_write), 0);
    funct3 = 3'b101;
    flag_lt = 1'b1;
    #1;
    chk("bge_not_taken", 32'(pc_write), 0);
    tick();
    chk("br_done", 32'(state_dbg), 1);
    op = 7'b1101111;
    #1;
    chk("jal_ext", 32'(extend_ctrl), 3'b100);
    tick();
    tick();
    chk("jal_state", 32'({state_dbg, pc_write, alu_src_a, alu_src_b, result_src}), 32'b1011_1_01_10_00);
    tick();
    chk("jal_aluwb", 32'({state_dbg, reg_write}), 32'b1001_1);
    tick();
    op = 7'b1100111;
    tick();
    tick();
    chk("jalr_state", 32'({state_dbg, alu_src_a, alu_src_b}), 32'b1100_10_01);
    tick();
    chk("jalr_to_jal", 32'(state_dbg), 11);
    tick();
    tick();
    chk("jalr_done", 32'(state_dbg), 1);
    op = 7'b0110111;
    #1;
    chk("lui_ext", 32'(extend_ctrl), 3'b011);
    tick();
    tick();
    chk("lui_state", 32'({state_dbg, result_src, reg_write}), 32'b1101_11_1);
    tick();
    op = 7'b0100011;
    #1;
    chk("sw_ext", 32'(extend_ctrl), 3'b001);
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    chk("sw_memwrite", 32'({state_dbg, mem_req, mem_write, adr_src}), 32'b0110_1_1_1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state_dbg), 0);
    chk("async_rst_req", 32'({mem_req, mem_write}), 0);
    tick();
    chk("async_rst_hold", 32'(state_dbg), 0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    chk("post_rst_fetch", 32'(state_dbg), 1);
    op = 7'b1111111;
    tick();
    tick();
    chk("illegal_trap", 32'({state_dbg, illegal, bus_err}), 32'b1111_1_0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      #1;
      chk("trap_quiet", 32'({state_dbg, strobes, illegal}), 32'b1111_00000_1);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("trap_rst", 32'({state_dbg, illegal}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wd_wait", 32'({state_dbg, mem_req, ir_write, bus_err}), 32'b0001_1_0_0);
      tick();
    end
    chk("wd_trap", 32'({state_dbg, bus_err, illegal, strobes}), 32'b1111_1_0_00000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, memory port and immediate extend unit.
- Drives extend_ctrl, the ALU operand muxes and the write strobes; handshakes with memory via mem_req/mem_ready.
- ALU function decode (funct3/funct7) lives in a separate ALU decoder; this block supplies only alu_op.

Parameters:
- MEM_TIMEOUT, 255: max cycles mem_req may wait for mem_ready before trapping; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- op  in  7  opcode from the instruction register.
- funct3  in  3  branch condition select.
- flag_zero  in  1  ALU result == 0.
- flag_lt  in  1  signed less-than.
- flag_ltu  in  1  unsigned less-than.
- mem_ready  in  1  memory completes the current request.
- mem_req  out  1  memory request.
- mem_write  out  1  request is a store.
- adr_src  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register and OldPC.
- pc_write  out  1  load PC from result.
- reg_write  out  1  register file write.
- result_src  out  2  result select: 00 ALUOut, 01 read data, 10 ALU result, 11 immExt.
- alu_src_a  out  2  operand A select: 00 PC, 01 OldPC, 10 rs1.
- alu_src_b  out  2  operand B select: 00 rs2, 01 immExt, 10 constant 4.
- alu_op  out  2  ALU mode: 00 add, 01 subtract/compare, 10 funct-decoded.
- extend_ctrl  out  3  immediate format: I=000, S=001, B=010, U=011, J=100.
- illegal  out  1  sticky: unknown opcode trapped.
- bus_err  out  1  sticky: memory timeout trapped.
- state_dbg  out  4  current state encoding.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECR=7, EXECI=8, ALUWB=9, BRANCH=10, JAL=11, JALR=12, LUI=13, TRAP=15.
- Reset:
  - rst_n low forces state=IDLE immediately (asynchronous), including mid-request.
  - All outputs are 0 in IDLE, including illegal, bus_err and the watchdog counter.
  - IDLE -> FETCH unconditionally on the next edge.
- Outputs are a Moore decode of state, with two exceptions:
  - extend_ctrl decodes from op in every state. lw, I-type and jalr give I; sw gives S; branches give B; lui/auipc give U; jal gives J; any other opcode gives I.
  - pc_write in BRANCH depends on the flags (see BRANCH).
- Strobes not listed for a state are 0. Mux selects not listed are don't-care and are driven 0.
- FETCH:
  - Drives mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - While mem_ready=0: hold state; ir_write=0, pc_write=0.
  - On mem_ready=1: ir_write=1 and pc_write=1 for that cycle, then -> DECODE.
- DECODE:
  - a=01, b=01, alu_op=00, so ALUOut = OldPC + imm.
  - Next state by op: lw/sw -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> ALUWB; otherwise -> TRAP with illegal=1.
- MEMADR: a=10, b=01, alu_op=00; lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1; hold until mem_ready, then -> MEMWB.
- MEMWB: result_src=01, reg_write=1; -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00; hold until mem_ready, then -> FETCH.
- EXECR: a=10, b=00, alu_op=10; -> ALUWB.
- EXECI: a=10, b=01, alu_op=10; -> ALUWB.
- ALUWB: result_src=00, reg_write=1; -> FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00; -> FETCH.
  - pc_write = taken, where taken is selected by funct3:
    - 000: flag_zero
    - 001: !flag_zero
    - 100: flag_lt
    - 101: !flag_lt
    - 110: flag_ltu
    - 111: !flag_ltu
    - 010 and 011: taken=0
- JALR: a=10, b=01, alu_op=00, so ALUOut = rs1 + imm; -> JAL.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1, so PC = ALUOut and the ALU computes OldPC+4; -> ALUWB.
- LUI: result_src=11, reg_write=1; -> FETCH.
- TRAP:
  - All strobes 0; illegal and bus_err hold their values.
  - Exit only via reset.
- Watchdog:
  - Counter clears on entry to FETCH, MEMREAD and MEMWRITE; increments each cycle mem_req=1 and mem_ready=0.
  - When the count reaches MEM_TIMEOUT with MEM_TIMEOUT != 0 and mem_ready is still 0: -> TRAP, bus_err=1.
  - mem_ready=1 on the same cycle wins over the timeout.
- Latency with zero-wait memory, FETCH through last state:
  - lw 5 cycles; jalr 5.
  - sw, R-type, I-type and jal 4 each.
  - branch, lui and auipc 3 each.

Test Plan:
- Reset, addi (op=0010011), mem_ready=1 -> state_dbg 0,1,2,8,9,1; extend_ctrl=000; reg_write=1 only in ALUWB.
- lw with mem_ready low for 3 cycles in MEMREAD -> 4 cycles in state 4 with mem_req=1 and adr_src=1; then MEMWB with result_src=01 and reg_write=1.
- Branches, extend_ctrl=010 throughout:
  - beq, flag_zero=1 -> pc_write=1 in BRANCH.
  - bne, flag_zero=1 -> pc_write=0.
  - bltu, flag_ltu=1 -> pc_write=1.
- jal -> extend_ctrl=100; JAL state shows pc_write=1, a=01, b=10; then ALUWB with reg_write=1.
- Trap cases:
  - op=1111111 -> TRAP (15) with illegal=1; strobes stay 0 for 20 cycles.
  - MEM_TIMEOUT=4, mem_ready=0 in FETCH -> TRAP with bus_err=1 after 4 waiting cycles.
- rst_n low mid-MEMWRITE with mem_req=1 -> mem_req, mem_write and state_dbg go to 0 before the next clk edge; after release, FETCH follows one cycle after IDLE.
